// File: rtl/identity_y_checker_if.sv
// rtl/identity_y_checker_if.sv - sample bus and result bus between a y-stream source and identity_y_checker
//
// Purpose: bundles the run control, the paired y samples and the
// registered verdict/signature outputs of identity_y_checker.
//
// Signals:
//   start              arm a new run (source -> checker)
//   sample_valid       y_ref / y_dut valid this cycle (source -> checker)
//   y_ref, y_dut       WIDTH-bit reference and synthesized y buses
//   busy, done, pass   run state and final verdict (checker -> source)
//   mismatch_count     mismatching samples this run (saturating)
//   sample_count       valid samples consumed this run
//   first_fail_*       location of the first mismatch
//   signature          32-bit MISR over y_dut
//
// Modports: master = sample source / bench, slave = checker.

interface identity_y_checker_if #(
    parameter int WIDTH = 319
);
    logic             start;
    logic             sample_valid;
    logic [WIDTH-1:0] y_ref;
    logic [WIDTH-1:0] y_dut;

    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      mismatch_count;
    logic [15:0]      sample_count;
    logic             first_fail_valid;
    logic [15:0]      first_fail_sample;
    logic [8:0]       first_fail_bit;
    logic [31:0]      signature;

    modport master (
        output start, sample_valid, y_ref, y_dut,
        input  busy, done, pass, mismatch_count, sample_count,
               first_fail_valid, first_fail_sample, first_fail_bit, signature
    );

    modport slave (
        input  start, sample_valid, y_ref, y_dut,
        output busy, done, pass, mismatch_count, sample_count,
               first_fail_valid, first_fail_sample, first_fail_bit, signature
    );
endinterface

// File: rtl/identity_y_checker.sv
// rtl/identity_y_checker.sv - compares reference vs synthesized y, counts mismatches, MISR over y_dut
//
// Purpose: consumes NUM_SAMPLES valid (y_ref, y_dut) pairs per run, counts
// samples that differ, records where the first difference occurred and
// compacts y_dut into a 32-bit MISR signature, ending with a pass/fail verdict.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    identity_y_checker_if.slave (start, sample_valid, y_ref, y_dut in;
//          busy, done, pass, counts, first_fail_*, signature out)

module identity_y_checker #(
    parameter int          WIDTH       = 319,
    parameter int          NUM_SAMPLES = 22,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] SEED        = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    identity_y_checker_if.slave   bus
);

    localparam int NCHUNK = (WIDTH + 31) / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [WIDTH-1:0]      diff;
    logic                  is_mismatch;
    logic [8:0]            diff_bit;
    logic [NCHUNK*32-1:0]  y_padded;
    logic [31:0]           fold;
    logic [31:0]           sig_next;
    logic [15:0]           sc_next;
    logic [15:0]           mm_next;

    assign diff        = bus.y_ref ^ bus.y_dut;
    assign is_mismatch = |diff;

    // Lowest differing bit: scan from the top so the lowest set index wins.
    always_comb begin
        diff_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff[i]) begin
                diff_bit = 9'(i);
            end
        end
    end

    // Fold y_dut into 32 bits; the partial top chunk is zero-extended.
    always_comb begin
        y_padded = (NCHUNK*32)'(bus.y_dut);
        fold     = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            fold = fold ^ y_padded[c*32 +: 32];
        end
    end

    assign sig_next = ({bus.signature[30:0], 1'b0} ^ (bus.signature[31] ? POLY : 32'h0)) ^ fold;
    assign sc_next  = bus.sample_count + 16'd1;
    assign mm_next  = (is_mismatch && (bus.mismatch_count != 16'hFFFF))
                      ? bus.mismatch_count + 16'd1 : bus.mismatch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.pass              <= 1'b0;
            bus.mismatch_count    <= '0;
            bus.sample_count      <= '0;
            bus.first_fail_valid  <= 1'b0;
            bus.first_fail_sample <= '0;
            bus.first_fail_bit    <= '0;
            bus.signature         <= SEED;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A sample arriving with start is dropped; counting begins next edge.
                    if (bus.start) begin
                        state                 <= RUN;
                        bus.busy              <= 1'b1;
                        bus.done              <= 1'b0;
                        bus.pass              <= 1'b0;
                        bus.mismatch_count    <= '0;
                        bus.sample_count      <= '0;
                        bus.first_fail_valid  <= 1'b0;
                        bus.first_fail_sample <= '0;
                        bus.first_fail_bit    <= '0;
                        bus.signature         <= SEED;
                    end
                end
                RUN: begin
                    if (bus.sample_valid) begin
                        bus.sample_count   <= sc_next;
                        bus.mismatch_count <= mm_next;
                        bus.signature      <= sig_next;
                        if (is_mismatch && !bus.first_fail_valid) begin
                            bus.first_fail_valid  <= 1'b1;
                            bus.first_fail_sample <= bus.sample_count;
                            bus.first_fail_bit    <= diff_bit;
                        end
                        if (sc_next == 16'(NUM_SAMPLES)) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (mm_next == 16'd0);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    bus.pass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_identity_y_checker.sv
// tb/tb_identity_y_checker.sv - scoreboard bench for identity_y_checker

module tb_identity_y_checker;

    localparam int          W    = 319;
    localparam int          N    = 22;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    typedef struct {
        logic [15:0] mm;
        logic        ffv;
        logic [15:0] ffs;
        logic [8:0]  ffb;
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [W-1:0] yr [N];
    logic [W-1:0] yd [N];
    exp_t         sb [$];

    identity_y_checker_if #(.WIDTH(W)) yif ();

    identity_y_checker #(
        .WIDTH(W), .NUM_SAMPLES(N), .POLY(POLY), .SEED(SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (yif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [W-1:0] y);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < W; i++) f[i % 32] = f[i % 32] ^ y[i];
        return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ f;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.mm = 0; e.ffv = 0; e.ffs = 0; e.ffb = 0; e.sig = SEED;
        for (int i = 0; i < N; i++) begin
            e.sig = model_step(e.sig, yd[i]);
            if (yr[i] != yd[i]) begin
                if (!e.ffv) begin
                    logic [W-1:0] d;
                    d     = yr[i] ^ yd[i];
                    e.ffv = 1'b1;
                    e.ffs = 16'(i);
                    for (int b = 0; b < W; b++) begin
                        if (d[b]) begin
                            e.ffb = 9'(b);
                            break;
                        end
                    end
                end
                e.mm++;
            end
        end
        e.pass = (e.mm == 0);
        sb.push_back(e);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < N; i++) begin
            yr[i] = '0;
            yd[i] = '0;
        end
    endtask

    task automatic fill_random();
        logic [319:0] t;
        for (int i = 0; i < N; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom};
            yr[i] = t[W-1:0];
            yd[i] = yr[i];
        end
    endtask

    task automatic arm();
        yif.start = 1'b1;
        @(negedge clk);
        yif.start = 1'b0;
        check("busy_after_start", 64'(yif.busy), 64'd1);
        check("count_after_start", 64'(yif.sample_count), 64'd0);
    endtask

    task automatic feed(input int n, input int gap, input bit chk_first);
        for (int i = 0; i < n; i++) begin
            yif.sample_valid = 1'b1;
            yif.y_ref        = yr[i];
            yif.y_dut        = yd[i];
            @(negedge clk);
            yif.sample_valid = 1'b0;
            if (chk_first && i == 0)
                check("sig_after_first", 64'(yif.signature), 64'h00000000FB3EE249);
            if (i < n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic finish_run(input string tag);
        exp_t e;
        for (int k = 0; k < 50 && !yif.done; k++) @(negedge clk);
        check({tag, "_done"}, 64'(yif.done), 64'd1);
        check({tag, "_busy"}, 64'(yif.busy), 64'd0);
        check({tag, "_sample_count"}, 64'(yif.sample_count), 64'(N));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_mismatch_count"}, 64'(yif.mismatch_count), 64'(e.mm));
            check({tag, "_pass"}, 64'(yif.pass), 64'(e.pass));
            check({tag, "_ff_valid"}, 64'(yif.first_fail_valid), 64'(e.ffv));
            if (e.ffv) begin
                check({tag, "_ff_sample"}, 64'(yif.first_fail_sample), 64'(e.ffs));
                check({tag, "_ff_bit"}, 64'(yif.first_fail_bit), 64'(e.ffb));
            end
            check({tag, "_signature"}, 64'(yif.signature), 64'(e.sig));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(yif.busy), 64'd0);
        check({tag, "_done"}, 64'(yif.done), 64'd0);
        check({tag, "_pass"}, 64'(yif.pass), 64'd0);
        check({tag, "_mm"}, 64'(yif.mismatch_count), 64'd0);
        check({tag, "_sc"}, 64'(yif.sample_count), 64'd0);
        check({tag, "_ffv"}, 64'(yif.first_fail_valid), 64'd0);
        check({tag, "_ffs"}, 64'(yif.first_fail_sample), 64'd0);
        check({tag, "_ffb"}, 64'(yif.first_fail_bit), 64'd0);
        check({tag, "_sig"}, 64'(yif.signature), 64'(SEED));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        yif.start        = 1'b0;
        yif.sample_valid = 1'b0;
        yif.y_ref        = '0;
        yif.y_dut        = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero run; also checks the signature after the first sample.
        fill_zero();
        push_expect();
        arm();
        feed(N, 0, 1'b1);
        finish_run("zero");
        check("zero_pass_const", 64'(yif.pass), 64'd1);

        // Single mismatch on sample 3, bits 5 and 200.
        fill_random();
        yd[3][5]   = ~yd[3][5];
        yd[3][200] = ~yd[3][200];
        push_expect();
        arm();
        feed(N, 0, 1'b0);
        finish_run("single");
        check("single_ffb_const", 64'(yif.first_fail_bit), 64'd5);

        // Same data, sample_valid every other cycle.
        push_expect();
        arm();
        feed(N, 1, 1'b0);
        finish_run("gapped");

        // Mismatches on samples 7 (bit 318) and 9.
        fill_random();
        yd[7][318] = ~yd[7][318];
        yd[9][10]  = ~yd[9][10];
        push_expect();
        arm();
        feed(N, 0, 1'b0);
        finish_run("double");
        check("double_ffs_const", 64'(yif.first_fail_sample), 64'd7);

        // Asynchronous reset after 10 samples (includes both mismatches).
        arm();
        feed(10, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        push_expect();
        arm();
        feed(N, 0, 1'b0);
        finish_run("after_reset");

        // start with sample_valid in DONE: run arms, sample dropped.
        yif.start        = 1'b1;
        yif.sample_valid = 1'b1;
        yif.y_ref        = yr[0];
        yif.y_dut        = ~yr[0];
        @(negedge clk);
        yif.start        = 1'b0;
        yif.sample_valid = 1'b0;
        check("restart_busy", 64'(yif.busy), 64'd1);
        check("restart_done", 64'(yif.done), 64'd0);
        check("restart_sc", 64'(yif.sample_count), 64'd0);
        check("restart_mm", 64'(yif.mismatch_count), 64'd0);
        check("restart_sig", 64'(yif.signature), 64'(SEED));
        fill_zero();
        push_expect();
        feed(N, 0, 1'b1);
        finish_run("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
